// File: rtl/booth_div_seq.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per clock, followed by a single sign fix-up cycle.
module booth_div_seq #(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic signed [N-1:0] dividend,
  input  logic signed [N-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic signed [N-1:0] quotient,
  output logic signed [N-1:0] remainder,
  output logic                div_by_zero,
  output logic                overflow
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [N:0]            rem_q, rem_d;
  logic [N-1:0]          qreg_q, qreg_d;
  logic [N-1:0]          dvsr_q, dvsr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sgnq_q, sgnq_d;
  logic                  sgnr_q, sgnr_d;
  logic signed [N-1:0]   quot_q, quot_d;
  logic signed [N-1:0]   remo_q, remo_d;
  logic                  dbz_q, dbz_d;
  logic                  ovf_q, ovf_d;

  logic                  accept;
  logic                  is_zero;
  logic                  is_ovf;
  logic [N:0]            shifted;
  logic [N:0]            trial;

  // Magnitude as N-bit unsigned, so the most negative value maps to 2^(N-1) exactly.
  function automatic logic [N-1:0] mag(input logic signed [N-1:0] v);
    logic [N-1:0] u;
    u = $unsigned(v);
    return v[N-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic signed [N-1:0] apply_sign(input logic neg, input logic [N-1:0] m);
    return neg ? $signed(~m + 1'b1) : $signed(m);
  endfunction

  assign accept  = start && !busy;
  assign is_zero = (divisor == '0);
  assign is_ovf  = (dividend == $signed({1'b1, {(N-1){1'b0}}})) && (divisor == '1);
  assign shifted = {rem_q[N-1:0], qreg_q[N-1]};
  assign trial   = shifted - {1'b0, dvsr_q};

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept)                state_d = (is_zero || is_ovf) ? S_DONE : S_RUN;
        else if (state_q == S_DONE) state_d = S_IDLE;
      end
      S_RUN:   if (cnt_q == CW'(N-1)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_FIX);
    done = (state_q == S_DONE);
  end

  always_comb begin
    rem_d  = rem_q;
    qreg_d = qreg_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    sgnq_d = sgnq_q;
    sgnr_d = sgnr_q;
    quot_d = quot_q;
    remo_d = remo_q;
    dbz_d  = dbz_q;
    ovf_d  = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (is_zero) begin
            quot_d = '1;
            remo_d = dividend;
            dbz_d  = 1'b1;
            ovf_d  = 1'b0;
          end else if (is_ovf) begin
            quot_d = dividend;
            remo_d = '0;
            dbz_d  = 1'b0;
            ovf_d  = 1'b1;
          end else begin
            rem_d  = '0;
            qreg_d = mag(dividend);
            dvsr_d = mag(divisor);
            cnt_d  = '0;
            sgnq_d = dividend[N-1] ^ divisor[N-1];
            sgnr_d = dividend[N-1];
          end
        end
      end
      S_RUN: begin
        // A negative trial difference means the divisor did not fit: restore.
        rem_d  = trial[N] ? shifted : trial;
        qreg_d = {qreg_q[N-2:0], ~trial[N]};
        cnt_d  = cnt_q + 1'b1;
      end
      S_FIX: begin
        quot_d = apply_sign(sgnq_q, qreg_q);
        remo_d = apply_sign(sgnr_q, rem_q[N-1:0]);
        dbz_d  = 1'b0;
        ovf_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      quot_q <= '0;
      remo_q <= '0;
      dbz_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      remo_q <= remo_d;
      dbz_q  <= dbz_d;
      ovf_q  <= ovf_d;
    end
    rem_q  <= rem_d;
    qreg_q <= qreg_d;
    dvsr_q <= dvsr_d;
    sgnq_q <= sgnq_d;
    sgnr_q <= sgnr_d;
  end

  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_booth_div_seq.sv
// Bench for booth_div_seq: vector table plus random ops through a result
// scoreboard, with hand-built sequences for ignored start, back-to-back and reset.
module tb_booth_div_seq;
  localparam int N = 8;

  typedef struct {
    logic signed [N-1:0] a;
    logic signed [N-1:0] b;
    logic [N-1:0]        q;
    logic [N-1:0]        r;
    logic                dbz;
    logic                ovf;
  } vec_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic signed [N-1:0] dividend = '0;
  logic signed [N-1:0] divisor = '0;
  logic                busy, done, div_by_zero, overflow;
  logic signed [N-1:0] quotient, remainder;

  int nvec = 0;
  int nerr = 0;
  vec_t sb[$];
  vec_t tbl[11];

  booth_div_seq #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
    vec_t v;
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    v.a = a; v.b = b; v.dbz = 1'b0; v.ovf = 1'b0;
    if (ib == 0) begin
      v.q = '1; v.r = a; v.dbz = 1'b1;
    end else if (ia == -(1 << (N-1)) && ib == -1) begin
      v.q = a; v.r = '0; v.ovf = 1'b1;
    end else begin
      v.q = N'(ia / ib);
      v.r = N'(ia % ib);
    end
    return v;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        vec_t e;
        e = sb.pop_front();
        check($sformatf("q_%0d_%0d", e.a, e.b), int'(quotient[N-1:0]), int'(e.q));
        check($sformatf("r_%0d_%0d", e.a, e.b), int'(remainder[N-1:0]), int'(e.r));
        check($sformatf("dbz_%0d_%0d", e.a, e.b), int'(div_by_zero), int'(e.dbz));
        check($sformatf("ovf_%0d_%0d", e.a, e.b), int'(overflow), int'(e.ovf));
      end
    end
  end

  // Called at a negedge; returns at the negedge inside the done cycle.
  task automatic run_op(input vec_t e, input int glitch_at);
    int cnt, busy_cnt, lat_exp;
    bit got;
    lat_exp = (e.dbz || e.ovf) ? 1 : N + 2;
    start = 1'b1; dividend = e.a; divisor = e.b;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    dividend = N'($urandom); divisor = N'($urandom);
    cnt = 1; busy_cnt = 0; got = 0;
    while (!got && cnt <= 40) begin
      if (busy) busy_cnt++;
      if (done) got = 1;
      else begin
        if (cnt == glitch_at) begin
          start = 1'b1; dividend = 50; divisor = 5;
        end else start = 1'b0;
        @(negedge clk);
        cnt++;
      end
    end
    start = 1'b0;
    check($sformatf("latency_%0d_%0d", e.a, e.b), cnt, lat_exp);
    check($sformatf("busy_cycles_%0d_%0d", e.a, e.b), busy_cnt, lat_exp - 1);
  endtask

  initial begin
    int ndone;
    tbl[0]  = '{a:  100, b:    7, q: 8'h0E, r: 8'h02, dbz: 0, ovf: 0};
    tbl[1]  = '{a: -100, b:    7, q: 8'hF2, r: 8'hFE, dbz: 0, ovf: 0};
    tbl[2]  = '{a:  100, b:   -7, q: 8'hF2, r: 8'h02, dbz: 0, ovf: 0};
    tbl[3]  = '{a:   37, b:    0, q: 8'hFF, r: 8'h25, dbz: 1, ovf: 0};
    tbl[4]  = '{a: -128, b:   -1, q: 8'h80, r: 8'h00, dbz: 0, ovf: 1};
    tbl[5]  = '{a: -128, b:    1, q: 8'h80, r: 8'h00, dbz: 0, ovf: 0};
    tbl[6]  = '{a:    0, b:    5, q: 8'h00, r: 8'h00, dbz: 0, ovf: 0};
    tbl[7]  = '{a:   -7, b:    2, q: 8'hFD, r: 8'hFF, dbz: 0, ovf: 0};
    tbl[8]  = '{a:  127, b: -128, q: 8'h00, r: 8'h7F, dbz: 0, ovf: 0};
    tbl[9]  = '{a: -128, b: -128, q: 8'h01, r: 8'h00, dbz: 0, ovf: 0};
    tbl[10] = '{a: -128, b:  127, q: 8'hFF, r: 8'hFF, dbz: 0, ovf: 0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(quotient[N-1:0]), 0);
    check("rst_r", int'(remainder[N-1:0]), 0);
    check("rst_flags", int'({div_by_zero, overflow}), 0);

    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i], 0);
      @(negedge clk);
    end

    for (int i = 0; i < 20; i++) begin
      logic signed [N-1:0] ra, rb;
      ra = N'($urandom);
      rb = (i % 7 == 3) ? '0 : N'($urandom);
      run_op(model(ra, rb), 0);
      @(negedge clk);
    end

    // Start pulsed mid-run is ignored; a start held during done chains directly.
    run_op(tbl[0], 4);
    run_op('{a: 50, b: 5, q: 8'h0A, r: 8'h00, dbz: 0, ovf: 0}, 0);
    @(negedge clk);

    // Reset mid-operation discards the op and clears outputs.
    start = 1'b1; dividend = 100; divisor = 7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_q", int'(quotient[N-1:0]), 0);
    check("midrst_r", int'(remainder[N-1:0]), 0);
    check("midrst_flags", int'({div_by_zero, overflow}), 0);
    ndone = 0;
    repeat (12) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    check("midrst_no_activity", ndone, 0);
    run_op('{a: 9, b: 2, q: 8'h04, r: 8'h01, dbz: 0, ovf: 0}, 0);
    @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
